sr_pulse_driver: RTL and testbench
==================================

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a button level change; legal range 2..65535.
REQ-002 Parameter PULSE_CYCLES, default 4: length of each active-low S or R pulse, in clock cycles; legal range 1..255.
REQ-003 Parameter GUARD_CYCLES, default 2: minimum high time on both S and R after a pulse ends, before the next pulse may start; legal range 1..255.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset; deassertion is synchronous to CLK.
REQ-006 BTN_SET  input  1  raw asynchronous active-high pushbutton; requests a latch set.
REQ-007 BTN_RST  input  1  raw asynchronous active-high pushbutton; requests a latch reset.
REQ-008 S  output  1  active-low set drive to the downstream NAND SR latch; registered.
REQ-009 R  output  1  active-low reset drive to the downstream NAND SR latch; registered.
REQ-010 BUSY  output  1  high while the FSM is not in IDLE; registered.
REQ-011 ERR  output  1  one-cycle high pulse when simultaneous set and reset requests are dropped; registered.

Function
REQ-012 Each button SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-013 Each synchronized button SHALL have its own debouncer. A counter is cleared whenever the synchronized level equals the debounced level. Otherwise it increments. The debounced level SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES, and the counter then clears.
REQ-014 A request SHALL be generated only on a 0->1 transition of a debounced level. A 1->0 transition generates nothing.
REQ-015 The FSM SHALL have exactly four states: IDLE, SET_P, RST_P, GUARD.
REQ-016 IDLE -> SET_P on a set request alone. IDLE -> RST_P on a reset request alone.
REQ-017 IDLE with set and reset requests in the same cycle SHALL stay in IDLE, drop both requests and pulse ERR high for one cycle.
REQ-018 SET_P and RST_P SHALL each last exactly PULSE_CYCLES cycles and then go to GUARD.
REQ-019 GUARD SHALL last exactly GUARD_CYCLES cycles and then go to IDLE.
REQ-020 Requests arriving in any state other than IDLE SHALL be discarded, not queued.
REQ-021 S SHALL be low exactly while the state is SET_P, and R exactly while the state is RST_P. S and R SHALL never be low in the same cycle, and the downstream latch SHALL never see the forbidden 0/0 input.
REQ-022 S SHALL fall on clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples BTN_SET high as edge 1, provided the input is held steady. R has the same latency for BTN_RST.
REQ-023 A button held high SHALL produce exactly one pulse, however long it is held.
REQ-024 All counters SHALL saturate or clear and SHALL never wrap.

Reset
REQ-025 While RST_N is low: S=1, R=1, BUSY=0, ERR=0, FSM=IDLE, all counters cleared, synchronizer flops and debounced levels at 0.
REQ-026 Reset asserted mid-pulse SHALL force S and R high immediately, asynchronously, without waiting for a clock edge.
REQ-027 A button already held high when RST_N deasserts SHALL be treated as a fresh press, i.e. it generates one request once debounced.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, GUARD_CYCLES=2)
REQ-028 BTN_SET held high for 20 cycles -> S low for exactly 3 cycles starting at edge 7; BUSY high for 5 cycles; R stays 1; only one pulse.
REQ-029 BTN_RST toggling every 2 cycles for 12 cycles, then held at 0 -> no R pulse, BUSY stays 0.
REQ-030 BTN_SET and BTN_RST rising on the same edge and held -> ERR high for 1 cycle at edge 7; S=R=1 throughout.
REQ-031 BTN_SET pulse accepted, then BTN_RST debounced during GUARD -> R never falls; BUSY returns to 0.
REQ-032 RST_N driven low in the 2nd cycle of S low -> S=1 before the next clock edge; after release, all outputs equal reset values until a new press.
REQ-033 Random button stimulus for 10k cycles -> assertion that S and R are never both 0, and every low pulse is exactly 3 cycles with at least 2 high cycles on both S and R between pulses.

Source files
------------

// File: rtl/sr_pulse_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_if
// Purpose  : Pushbutton inputs and SR-latch drive outputs of sr_pulse_driver.
//            The master side presses the buttons and watches the latch drive;
//            the slave side is the driver itself.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_pulse_if;
    logic btn_set;
    logic btn_rst;
    logic s;
    logic r;
    logic busy;
    logic err;

    modport master (
        output btn_set,
        output btn_rst,
        input  s,
        input  r,
        input  busy,
        input  err
    );

    modport slave (
        input  btn_set,
        input  btn_rst,
        output s,
        output r,
        output busy,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/sr_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_driver
// Purpose  : Turns two raw pushbuttons into clean, mutually exclusive
//            active-low set/reset pulses for a downstream NAND SR latch.
//            Each button is synchronized and debounced. A rising debounced
//            level raises a one-cycle request, and a four-state FSM times
//            the pulse and the guard gap that follows it.
// Revision : 1.0 - initial release
// ============================================================================
module sr_pulse_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned GUARD_CYCLES    = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sr_pulse_if.slave bus
);

    localparam logic [15:0] c_deb_last   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  c_pulse_last = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0]  c_guard_last = 8'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        GUARD = 2'd3
    } state_t;

    // Bit 0 is the set channel, bit 1 is the reset channel.
    logic [1:0] w_btn_raw;
    logic [1:0] w_req;

    assign w_btn_raw = {bus.btn_rst, bus.btn_set};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic        r_sync1;
            logic        r_sync2;
            logic        r_deb;
            logic        r_deb_d;
            logic [15:0] r_cnt;

            // Two-flop synchronizer for the raw asynchronous button.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Debouncer. The counter runs only while the synchronized level
            // differs from the accepted level. It never passes
            // DEBOUNCE_CYCLES-1, so it cannot wrap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_deb_d <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_last) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            end

            // A request is a single cycle on the 0->1 debounced edge only.
            // The debounced levels reset to 0, so a button held through reset
            // counts as a fresh press.
            assign w_req[gi] = r_deb & ~r_deb_d;
        end
    endgenerate

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_tmr;
    logic [7:0] w_tmr_nxt;
    logic       w_err_nxt;
    logic       r_s;
    logic       r_r;
    logic       r_busy;
    logic       r_err;

    // Next-state logic. The timer counts cycles spent in the current state
    // and is cleared on every state change. A request that arrives outside
    // IDLE is a one-cycle pulse, so it is lost rather than queued.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_tmr_nxt = '0;
                if (w_req == 2'b11) begin
                    w_err_nxt = 1'b1;
                end else if (w_req[0]) begin
                    w_state_nxt = SET_P;
                end else if (w_req[1]) begin
                    w_state_nxt = RST_P;
                end
            end
            SET_P, RST_P: begin
                if (r_tmr == c_pulse_last) begin
                    w_state_nxt = GUARD;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 8'd1;
                end
            end
            GUARD: begin
                if (r_tmr == c_guard_last) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    // State register. The outputs are decoded from the next state, so S and
    // R are registered yet low exactly while the state is SET_P or RST_P.
    // Because the state is a single encoding, S and R can never be low
    // together. The asynchronous reset drives S and R high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_s     <= 1'b1;
            r_r     <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_s     <= (w_state_nxt != SET_P);
            r_r     <= (w_state_nxt != RST_P);
            r_busy  <= (w_state_nxt != IDLE);
            r_err   <= w_err_nxt;
        end
    end

    assign bus.s    = r_s;
    assign bus.r    = r_r;
    assign bus.busy = r_busy;
    assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_pulse_driver
// Purpose  : Scoreboard bench for sr_pulse_driver (DEBOUNCE=4, PULSE=3,
//            GUARD=2). Stimulus pushes the expected output events (S low, R
//            low, ERR high, BUSY high: start edge and length) into a queue.
//            A monitor pops and compares each event as it completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_pulse_driver;

    localparam int D = 4;
    localparam int P = 3;
    localparam int G = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    sr_pulse_if bus ();

    sr_pulse_driver #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (P),
        .GUARD_CYCLES   (G)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock and a count of rising edges seen so far.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0=S low, 1=R low, 2=ERR high, 3=BUSY high
        int start;  // edge number on which the level first appears
        int len;    // cycles the level is held
    } ev_t;

    ev_t   exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    bit    sb_on = 1'b1;
    string kname[4] = '{"S", "R", "ERR", "BUSY"};

    task automatic push(input int k, input int st, input int ln);
        ev_t e;
        e.kind  = k;
        e.start = st;
        e.len   = ln;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    logic [3:0] was = 4'b0;
    int         st[4];
    int         ln[4];
    int         hi_run = 100;

    task automatic finish_ev(input int k);
        ev_t e;
        if (sb_on) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_%s: got start %0d len %0d, expected no event",
                         kname[k], st[k], ln[k]);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k || e.start != st[k] || e.len != ln[k]) begin
                    n_bad++;
                    $display("FAIL event: got %s start %0d len %0d, expected %s start %0d len %0d",
                             kname[k], st[k], ln[k], kname[e.kind], e.start, e.len);
                end
            end
        end else if (k < 2) begin
            n_vec++;
            if (ln[k] != P) begin
                n_bad++;
                $display("FAIL pulse_len_%s: got %0d expected %0d (start %0d)",
                         kname[k], ln[k], P, st[k]);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] act;
        act = {bus.busy, bus.err, ~bus.r, ~bus.s};
        n_vec++;
        if (act[0] === 1'b1 && act[1] === 1'b1) begin
            n_bad++;
            $display("FAIL s_r_both_low: got S=%b R=%b expected not both 0 (edge %0d)",
                     bus.s, bus.r, cyc);
        end
        for (int k = 0; k < 4; k++) begin
            if (act[k] && !was[k]) begin
                st[k] = cyc;
                ln[k] = 1;
                if (k < 2) begin
                    n_vec++;
                    if (hi_run < G) begin
                        n_bad++;
                        $display("FAIL guard_gap_%s: got %0d high cycles expected >= %0d (edge %0d)",
                                 kname[k], hi_run, G, cyc);
                    end
                end
            end else if (act[k] && was[k]) begin
                ln[k] = ln[k] + 1;
            end else if (!act[k] && was[k]) begin
                finish_ev(k);
            end
        end
        hi_run = (act[1:0] == 2'b00) ? hi_run + 1 : 0;
        was    = act;
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        rst_n       = 1'b0;

        // Reset state
        tick(1);
        chk("reset_s", bus.s, 1'b1);
        chk("reset_r", bus.r, 1'b1);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_err", bus.err, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        // Long set press: one 3-cycle S pulse at edge 7, busy for 5 cycles
        c = cyc;
        bus.btn_set = 1'b1;
        push(0, c + 7, P);
        push(3, c + 7, P + G);
        tick(20);
        bus.btn_set = 1'b0;
        tick(12);

        // Bouncing reset button: never stable long enough, so no event
        repeat (3) begin
            bus.btn_rst = 1'b1;
            tick(2);
            bus.btn_rst = 1'b0;
            tick(2);
        end
        tick(12);

        // Simultaneous presses: a single ERR cycle at edge 7 and no pulses
        c = cyc;
        bus.btn_set = 1'b1;
        bus.btn_rst = 1'b1;
        push(2, c + 7, 1);
        tick(20);
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        tick(12);

        // Reset request debounced while in GUARD is discarded
        c = cyc;
        bus.btn_set = 1'b1;
        push(0, c + 7, P);
        push(3, c + 7, P + G);
        tick(4);
        bus.btn_rst = 1'b1;
        tick(20);
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        tick(12);

        // Asynchronous reset in the second cycle of S low
        c = cyc;
        bus.btn_set = 1'b1;
        push(0, c + 7, 1);
        push(3, c + 7, 1);
        tick(7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_s", bus.s, 1'b1);
        chk("async_rst_r", bus.r, 1'b1);
        chk("async_rst_busy", bus.busy, 1'b0);
        bus.btn_set = 1'b0;
        tick(3);
        rst_n = 1'b1;
        repeat (15) begin
            tick(1);
            chk("post_rst_s", bus.s, 1'b1);
            chk("post_rst_r", bus.r, 1'b1);
            chk("post_rst_busy", bus.busy, 1'b0);
            chk("post_rst_err", bus.err, 1'b0);
        end

        // Button held through reset release is a fresh press
        bus.btn_rst = 1'b1;
        rst_n = 1'b0;
        tick(2);
        c = cyc;
        rst_n = 1'b1;
        push(1, c + 7, P);
        push(3, c + 7, P + G);
        tick(20);
        bus.btn_rst = 1'b0;
        tick(12);

        // Random buttons: only the invariants are checked
        sb_on = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if ($urandom_range(0, 7) == 0) bus.btn_set = ~bus.btn_set;
            if ($urandom_range(0, 7) == 0) bus.btn_rst = ~bus.btn_rst;
        end
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        tick(30);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
